// File: rtl/adc_hyst_pkg.sv
// Shared types, default sizes and sample classification for the multi-channel
// ADC hysteresis comparator.
package adc_hyst_pkg;

   localparam int unsigned DEFAULT_DATA_W   = 12;
   localparam int unsigned DEFAULT_N_CH     = 4;
   localparam int unsigned DEFAULT_DEBOUNCE = 3;

   typedef enum logic [1:0] {
      ZONE_LOW,
      ZONE_MID,
      ZONE_HIGH
   } zone_e;

   // Values equal to a threshold are MID; an inverted threshold pair makes everything MID.
   function automatic zone_e classify(input logic [31:0] sample,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
      if (lo >= hi) return ZONE_MID;
      if (sample < lo) return ZONE_LOW;
      if (sample > hi) return ZONE_HIGH;
      return ZONE_MID;
   endfunction

endpackage

// File: rtl/adc_hyst_chan.sv
// One channel of the hysteresis comparator: debounce counter, can_move_fwd flag
// and a registered one-cycle trip pulse when the flag toggles.
module adc_hyst_chan
   import adc_hyst_pkg::*;
#(
   parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  en_i,
   input  zone_e zone_i,
   output logic  flag_o,
   output logic  trip_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flag_q, flag_d;
   logic             trip_q, trip_d;
   logic             opposite;

   assign opposite = flag_q ? (zone_i == ZONE_HIGH) : (zone_i == ZONE_LOW);

   always_comb begin
      cnt_d  = cnt_q;
      flag_d = flag_q;
      trip_d = 1'b0;
      if (en_i) begin
         if (!opposite) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
            cnt_d  = '0;
            flag_d = ~flag_q;
            trip_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         flag_q <= 1'b1;
         trip_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
         trip_q <= trip_d;
      end
   end

   assign flag_o = flag_q;
   assign trip_o = trip_q;

endmodule

// File: rtl/adc_hyst_multi.sv
// Multi-channel ADC hysteresis comparator: capture stage, then classify and debounce.
// Define ADC_HYST_RUNTIME_THR_EN to take thresholds from cfg_low_i/cfg_high_i.
module adc_hyst_multi
   import adc_hyst_pkg::*;
#(
   parameter int unsigned DATA_W   = DEFAULT_DATA_W,
   parameter int unsigned N_CH     = DEFAULT_N_CH,
   parameter int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
   parameter int unsigned X_HIGH   = 3000,
   parameter int unsigned X_LOW    = 1000,
   parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              adc_ready_i,
   input  logic [CH_W-1:0]   adc_ch_i,
   input  logic [DATA_W-1:0] d_signal_i,
`ifdef ADC_HYST_RUNTIME_THR_EN
   input  logic [DATA_W-1:0] cfg_low_i,
   input  logic [DATA_W-1:0] cfg_high_i,
`endif
   output logic              adc_ack_o,
   output logic [N_CH-1:0]   can_move_fwd_o,
   output logic [N_CH-1:0]   trip_o,
   output logic              bad_ch_o
);

   logic              valid_q;
   logic [CH_W-1:0]   ch_q;
   logic [DATA_W-1:0] data_q;
   logic              bad_ch_q;
   logic [31:0]       thr_lo, thr_hi;
   logic              ch_bad;
   zone_e             zone;
   logic [N_CH-1:0]   chan_en;

`ifdef ADC_HYST_RUNTIME_THR_EN
   assign thr_lo = 32'(cfg_low_i);
   assign thr_hi = 32'(cfg_high_i);
`else
   assign thr_lo = X_LOW;
   assign thr_hi = X_HIGH;
`endif

   // Stage 1: every strobe is accepted, so the ack is just the registered valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         ch_q    <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= adc_ready_i;
         if (adc_ready_i) begin
            ch_q   <= adc_ch_i;
            data_q <= d_signal_i;
         end
      end
   end

   assign zone   = classify(32'(data_q), thr_lo, thr_hi);
   assign ch_bad = (32'(ch_q) >= N_CH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bad_ch_q <= 1'b0;
      end else begin
         bad_ch_q <= valid_q && ch_bad;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      assign chan_en[i] = valid_q && (32'(ch_q) == i);

      adc_hyst_chan #(
         .DEBOUNCE(DEBOUNCE)
      ) u_chan (
         .clk   (clk),
         .rst   (rst),
         .en_i  (chan_en[i]),
         .zone_i(zone),
         .flag_o(can_move_fwd_o[i]),
         .trip_o(trip_o[i])
      );
   end

   assign adc_ack_o = valid_q;
   assign bad_ch_o  = bad_ch_q;

endmodule
